// File: rtl/cpu_bus_target.sv
// cpu_bus_target: CPU bus slave exposing a 16-word register window.
//   Registers 0..13 are read/write.
//   Register 14 is a read-only count of accepted accesses.
//   Register 15 is a read-only free-running cycle counter.
//   An access starts on a 0->1 edge of i_bus_clk. It is acknowledged with a
//   one-cycle o_bus_data_ready pulse WAIT_STATES+1 cycles after the edge
//   is detected.
// Ports:
//   i_cpu_clk        clock, all state on its rising edge
//   i_rst            asynchronous, active-high reset
//   i_bus_clk        request strobe; a rising edge starts one access
//   i_bus_we         1 = write, 0 = read, sampled with the request edge
//   i_bus_addr       word address of the access
//   i_bus_data       write data
//   o_bus_data       read data, held until the next read completes
//   o_bus_data_ready one-cycle acknowledge
//   o_busy           high whenever the FSM is not idle
//   o_reg0           live contents of register 0
//
// state  | meaning
// S_IDLE | waiting for a request edge that hits the window
// S_WAIT | counting down wait states for an accepted access
// S_ACK  | acknowledge cycle; write/read took effect on entry
// S_HOLD | waiting for i_bus_clk to return low
module cpu_bus_target #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_FF00,
  parameter int          WAIT_STATES = 2
) (
  input  logic        i_cpu_clk,
  input  logic        i_rst,
  input  logic        i_bus_clk,
  input  logic        i_bus_we,
  input  logic [31:0] i_bus_addr,
  input  logic [31:0] i_bus_data,
  output logic [31:0] o_bus_data,
  output logic        o_bus_data_ready,
  output logic        o_busy,
  output logic [31:0] o_reg0
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_HOLD} state_t;

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t      state;
  logic        bus_clk_q;
  logic [3:0]  wait_cnt;
  logic        we_q;
  logic [3:0]  idx_q;
  logic [31:0] wdata_q;
  logic [31:0] regs [0:13];
  logic [31:0] acc_cnt;
  logic [31:0] cyc_cnt;

  logic        req_edge;
  logic        hit;
  logic        start;
  logic        enter_ack;
  logic        acc_we;
  logic [3:0]  acc_idx;
  logic [31:0] acc_wdata;
  logic [31:0] rd_val;

  assign req_edge = i_bus_clk & ~bus_clk_q;
  assign hit      = (i_bus_addr[31:4] == BASE_ADDR[31:4]);
  assign start    = (state == S_IDLE) && req_edge && hit;

  // With zero wait states, ACK is entered straight from IDLE. The access
  // attributes then come from the bus rather than the latches.
  assign enter_ack = (start && (WS == 4'd0)) ||
                     ((state == S_WAIT) && (wait_cnt == 4'd1));

  assign acc_we    = start ? i_bus_we        : we_q;
  assign acc_idx   = start ? i_bus_addr[3:0] : idx_q;
  assign acc_wdata = start ? i_bus_data      : wdata_q;

  // A read of register 14 must include the current access. In the
  // zero-wait case, the increment has not landed yet when the read is made.
  always_comb begin
    rd_val = '0;
    case (acc_idx)
      4'd14:   rd_val = start ? (acc_cnt + 32'd1) : acc_cnt;
      4'd15:   rd_val = cyc_cnt;
      default: rd_val = regs[acc_idx];
    endcase
  end

  assign o_busy = (state != S_IDLE);
  assign o_reg0 = regs[0];

  always_ff @(posedge i_cpu_clk or posedge i_rst) begin
    if (i_rst) begin
      state            <= S_IDLE;
      // Reset high so a strobe held high through reset release is not an edge.
      bus_clk_q        <= 1'b1;
      wait_cnt         <= '0;
      we_q             <= 1'b0;
      idx_q            <= '0;
      wdata_q          <= '0;
      acc_cnt          <= '0;
      cyc_cnt          <= '0;
      o_bus_data       <= '0;
      o_bus_data_ready <= 1'b0;
      for (int i = 0; i < 14; i++) regs[i] <= '0;
    end else begin
      bus_clk_q        <= i_bus_clk;
      cyc_cnt          <= cyc_cnt + 32'd1;
      o_bus_data_ready <= 1'b0;

      if (start) begin
        we_q    <= i_bus_we;
        idx_q   <= i_bus_addr[3:0];
        wdata_q <= i_bus_data;
        acc_cnt <= acc_cnt + 32'd1;
      end

      if (enter_ack) begin
        if (acc_we) begin
          if (acc_idx < 4'd14) regs[acc_idx] <= acc_wdata;
        end else begin
          o_bus_data <= rd_val;
        end
        o_bus_data_ready <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            wait_cnt <= WS;
            state    <= (WS == 4'd0) ? S_ACK : S_WAIT;
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) state <= S_ACK;
        end
        S_ACK: state <= S_HOLD;
        S_HOLD: begin
          if (!i_bus_clk) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
